// File: rtl/rr_onehot_arbiter.sv
// Round-robin valid/ready arbiter: a one-hot grant selects one requester's word
// into a single-entry registered output stage. The winner drops to lowest priority.
module rr_onehot_arbiter #(
    parameter int unsigned Count = 3,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Count-1:0] req_valid_i,
    output logic [Count-1:0] req_ready_o,
    input  logic [Width-1:0] req_words_i [Count],
    output logic [Count-1:0] grant_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_word_o,
    output logic [Count-1:0] out_source_o
);

    logic [Count-1:0] ptr;
    logic [Count-1:0] ptr_next;
    logic [Count-1:0] mask_hi;
    logic [Count-1:0] req_hi;
    logic [Count-1:0] pick;
    logic [Width-1:0] mux_word;
    logic             load;

    assign load = !out_valid_o || out_ready_i;

    // Requests at or above the pointer win first; if none, wrap to the lowest-index request.
    always_comb begin
        mask_hi = ~(ptr - Count'(1));
        req_hi  = req_valid_i & mask_hi;
        if (req_hi != '0) begin
            pick = req_hi & (~req_hi + Count'(1));
        end else begin
            pick = req_valid_i & (~req_valid_i + Count'(1));
        end
        grant_o = load ? pick : '0;
    end

    assign req_ready_o = grant_o;

    always_comb begin
        ptr_next = '0;
        mux_word = '0;
        for (int unsigned i = 0; i < Count; i++) begin
            ptr_next[(i + 1) % Count] = grant_o[i];
            mux_word = mux_word | (req_words_i[i] & {Width{grant_o[i]}});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr          <= Count'(1);
            out_valid_o  <= 1'b0;
            out_word_o   <= '0;
            out_source_o <= '0;
        end else if (grant_o != '0) begin
            ptr          <= ptr_next;
            out_valid_o  <= 1'b1;
            out_word_o   <= mux_word;
            out_source_o <= grant_o;
        end else if (load) begin
            out_valid_o  <= 1'b0;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(grant_o));
    a_ptr_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot(ptr));
    a_grant_subset : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (grant_o & ~req_valid_i) == '0);
    a_source_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o |-> $onehot(out_source_o));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scenario bench for rr_onehot_arbiter (Count=3, Width=8) with a drain-side scoreboard.
`timescale 1ns/1ps
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] req_ready;
    logic [7:0] words [3];
    logic [2:0] grant;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [2:0] out_source;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] word;
        logic [2:0] src;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.Count(3), .Width(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (valid),
        .req_ready_o  (req_ready),
        .req_words_i  (words),
        .grant_o      (grant),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_word_o   (out_word),
        .out_source_o (out_source)
    );

    // A word leaves on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got word %h src %b, want no word", out_word, out_source);
            end else begin
                e = sb.pop_front();
                if (out_word !== e.word || out_source !== e.src) begin
                    errors++;
                    $display("FAIL sb_word: got word %h src %b, want word %h src %b",
                             out_word, out_source, e.word, e.src);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; valid = 3'b000; out_ready = 1'b0;
        words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
        #12 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_word !== 8'h00 || out_source !== 3'b000) begin
            errors++;
            $display("FAIL reset_regs: got word %h src %b, want 00 000", out_word, out_source);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b0 || grant !== 3'b000 || dut.ptr !== 3'b001) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got valid %b grant %b ptr %b, want 0 000 001",
                         i, out_valid, grant, dut.ptr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] rot_w [3];
        logic [2:0] exp_g;
        rot_w[0] = 8'hA0; rot_w[1] = 8'hB1; rot_w[2] = 8'hC2;
        @(posedge clk); #1;
        words[0] = 8'hA0; words[1] = 8'hB1; words[2] = 8'hC2;
        valid = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'b001 << (i % 3);
            @(negedge clk);
            checks++;
            if (grant !== exp_g || req_ready !== exp_g) begin
                errors++;
                $display("FAIL rot_grant[%0d]: got grant %b ready %b, want %b", i, grant, req_ready, exp_g);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rot_no_bubble[%0d]: got out_valid %b, want 1", i, out_valid);
                end
            end
            sb.push_back('{word: rot_w[i % 3], src: exp_g});
            @(posedge clk);
        end
        #1 valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dut.ptr !== 3'b001) begin
            errors++;
            $display("FAIL rot_end: got out_valid %b ptr %b, want 0 001", out_valid, dut.ptr);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g;
        @(posedge clk); #1;
        words[0] = 8'h10; words[1] = 8'h21; words[2] = 8'h32;
        valid = 3'b110; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 3'b010 : 3'b100;
            @(negedge clk);
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b, want %b", i, grant, exp_g);
            end
            sb.push_back('{word: (i % 2 == 0) ? 8'h21 : 8'h32, src: exp_g});
            @(posedge clk);
        end
        #1 valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        words[0] = 8'h55; words[1] = 8'h66; words[2] = 8'h77;
        valid = 3'b111; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL bp_first: got grant %b, want 001", grant);
        end
        sb.push_back('{word: 8'h55, src: 3'b001});
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000 || grant !== 3'b000 || out_valid !== 1'b1 ||
                out_word !== 8'h55 || out_source !== 3'b001) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got ready %b grant %b valid %b word %h src %b, want 000 000 1 55 001",
                         i, req_ready, grant, out_valid, out_word, out_source);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got grant %b, want 010", grant);
        end
        sb.push_back('{word: 8'h66, src: 3'b010});
        @(negedge clk);
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL bp_next: got grant %b, want 100", grant);
        end
        sb.push_back('{word: 8'h77, src: 3'b100});
        @(posedge clk); #1 valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid %b, want 0", out_valid);
        end
    endtask

    task automatic test_withdrawal();
        @(posedge clk); #1;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        valid = 3'b101; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL wd_grant: got grant %b ready %b, want 001", grant, req_ready);
        end
        sb.push_back('{word: 8'h11, src: 3'b001});
        @(posedge clk); #1 valid = 3'b000;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL wd_dropped: got grant %b, want 000", grant);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dut.ptr !== 3'b010) begin
            errors++;
            $display("FAIL wd_end: got out_valid %b ptr %b, want 0 010", out_valid, dut.ptr);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(posedge clk); #1;
        words[0] = 8'h44; words[1] = 8'h22; words[2] = 8'h99;
        valid = 3'b010; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || dut.ptr !== 3'b100) begin
            errors++;
            $display("FAIL rst_pre: got out_valid %b ptr %b, want 1 100", out_valid, dut.ptr);
        end
        #2 rst_n = 1'b0; valid = 3'b000;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.ptr !== 3'b001 || grant !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: got out_valid %b ptr %b grant %b, want 0 001 000",
                     out_valid, dut.ptr, grant);
        end
        sb.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        valid = 3'b110; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL rst_next_grant: got %b, want 010", grant);
        end
        sb.push_back('{word: 8'h22, src: 3'b010});
        @(posedge clk); #1 valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rotation();
        test_fairness();
        test_backpressure();
        test_withdrawal();
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending words, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
